// File: rtl/arbiter.sv
// Request arbiter with fixed or round-robin priority and a combinational grant.
// It forwards an OR-of-requests upstream and issues its one-hot grant only when the parent grants the group.
module arbiter #(
    parameter int N_REQ   = 4,
    parameter bit RR_MODE = 1'b0
) (
    input  logic             clock_IN,
    input  logic             reset_n_IN,
    input  logic [N_REQ-1:0] requests_IN,
    input  logic             group_grant_IN,
    output logic [N_REQ-1:0] grants_OUT,
    output logic             group_request_OUT
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    ptr;
    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] grant;

    assign group_request_OUT = |requests_IN;

    // Requests at or above ptr take precedence; if there are none, the search wraps to the full vector.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N_REQ; i++)
            hi_mask[i] = (PW'(i) >= ptr);
        masked = requests_IN & hi_mask;
        pick   = (|masked) ? masked : requests_IN;
        grant  = pick & (~pick + N_REQ'(1));
        if (!group_grant_IN)
            grant = '0;
    end

    assign grants_OUT = grant;

    generate
        if (RR_MODE) begin : g_rr
            logic [PW-1:0] nxt_ptr;

            always_comb begin
                nxt_ptr = '0;
                for (int i = 0; i < N_REQ - 1; i++)
                    if (grant[i])
                        nxt_ptr = PW'(i + 1);
            end

            always_ff @(posedge clock_IN or negedge reset_n_IN) begin
                if (!reset_n_IN)
                    ptr <= '0;
                else if (|grant)
                    ptr <= nxt_ptr;
            end
        end else begin : g_fixed
            assign ptr = '0;
        end
    endgenerate

endmodule

// File: tb/tb_arbiter.sv
// Directed scoreboard bench for arbiter: fixed-priority and round-robin instances share the same stimulus.
// Expected grants are pushed when inputs are driven and popped when the outputs are sampled.
module tb_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       gg;
    logic [3:0] g0, g1;
    logic       gr0, gr1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [3:0] e0;
        logic [3:0] e1;
        logic       er;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    arbiter #(.N_REQ(4), .RR_MODE(1'b0)) d0 (
        .clock_IN(clk), .reset_n_IN(rst_n), .requests_IN(req),
        .group_grant_IN(gg), .grants_OUT(g0), .group_request_OUT(gr0));

    arbiter #(.N_REQ(4), .RR_MODE(1'b1)) d1 (
        .clock_IN(clk), .reset_n_IN(rst_n), .requests_IN(req),
        .group_grant_IN(gg), .grants_OUT(g1), .group_request_OUT(gr1));

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (g0 === e.e0) else begin
            failures++;
            $error("FAIL %s fixed grants observed=%b expected=%b", e.tag, g0, e.e0);
        end
        checks++;
        assert (g1 === e.e1) else begin
            failures++;
            $error("FAIL %s rr grants observed=%b expected=%b", e.tag, g1, e.e1);
        end
        checks++;
        assert (gr0 === e.er) else begin
            failures++;
            $error("FAIL %s fixed group_request observed=%b expected=%b", e.tag, gr0, e.er);
        end
        checks++;
        assert (gr1 === e.er) else begin
            failures++;
            $error("FAIL %s rr group_request observed=%b expected=%b", e.tag, gr1, e.er);
        end
    endtask

    // Drive inputs, queue expectations, and sample 1 time unit later, away from the clock edge.
    task automatic step(input string tag, input logic [3:0] r, input logic g,
                        input logic [3:0] e0, input logic [3:0] e1, input logic er);
        exp_t e;
        req = r;
        gg  = g;
        e.tag = tag; e.e0 = e0; e.e1 = e1; e.er = er;
        sb.push_back(e);
        #1;
        check();
    endtask

    task automatic edge_();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        gg    = 1'b0;
        #1;
        step("reset_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("reset_live", 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1);
        edge_();
        step("reset_hold", 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step("rel_no_upd", 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // Fixed-priority vectors; the RR instance follows its own pointer (0,1,0,1,2).
        step("fix_0001", 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1); edge_();
        step("fix_1001", 4'b1001, 1'b1, 4'b0001, 4'b1000, 1'b1); edge_();
        step("fix_0011", 4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1); edge_();
        step("fix_0110", 4'b0110, 1'b1, 4'b0010, 4'b0010, 1'b1); edge_();
        step("fix_0000", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0); edge_();

        // Parent withholds the grant for three edges; the RR pointer must stay at 2.
        for (int k = 0; k < 3; k++) begin
            step("no_gg", 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1);
            edge_();
        end
        step("ptr_held2", 4'b1111, 1'b1, 4'b0001, 4'b0100, 1'b1); edge_();

        // Pointer is now 3: a mid-cycle reset must switch the RR grant immediately.
        step("ptr3_1010", 4'b1010, 1'b1, 4'b0010, 4'b1000, 1'b1);
        rst_n = 1'b0;
        #1;
        step("async_rst", 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Round-robin rotation from pointer 0.
        step("rr_0", 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1); edge_();
        step("rr_1", 4'b1111, 1'b1, 4'b0001, 4'b0010, 1'b1); edge_();
        step("rr_2", 4'b1111, 1'b1, 4'b0001, 4'b0100, 1'b1); edge_();
        step("rr_3", 4'b1111, 1'b1, 4'b0001, 4'b1000, 1'b1); edge_();
        step("rr_4", 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1); edge_();

        // Pointer 1 -> grant index 1 -> pointer 2, then a wrap-around search.
        step("to_ptr2", 4'b1111, 1'b1, 4'b0001, 4'b0010, 1'b1); edge_();
        step("wrap_0011", 4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1); edge_();
        step("after_wrap", 4'b1111, 1'b1, 4'b0001, 4'b0010, 1'b1); edge_();

        // Requests change within one cycle: the grant follows with no hold.
        step("comb_a", 4'b1100, 1'b1, 4'b0100, 4'b0100, 1'b1);
        step("comb_b", 4'b1001, 1'b1, 4'b0001, 4'b1000, 1'b1);
        step("comb_c", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
